// File: rtl/core_mem_arb.sv
// core_mem_arb: shares one memory port between IFU fetches and LSU loads/stores.
// Optional feature macro: CORE_MEM_ARB_RR_EN (round-robin arbitration on simultaneous requests;
// when undefined, LSU has fixed priority over IFU).
module core_mem_arb #(
    parameter int XLEN   = 32,
    parameter int STRB_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ifu_req_valid,
    output logic              ifu_req_ready,
    input  logic [XLEN-1:0]   ifu_req_addr,
    output logic              ifu_rsp_valid,
    output logic [XLEN-1:0]   ifu_rsp_rdata,
    input  logic              lsu_req_valid,
    output logic              lsu_req_ready,
    input  logic              lsu_req_wen,
    input  logic [XLEN-1:0]   lsu_req_addr,
    input  logic [STRB_W-1:0] lsu_req_wstrb,
    input  logic [XLEN-1:0]   lsu_req_wdata,
    output logic              lsu_rsp_valid,
    output logic [XLEN-1:0]   lsu_rsp_rdata,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_wen,
    output logic [XLEN-1:0]   mem_req_addr,
    output logic [STRB_W-1:0] mem_req_wstrb,
    output logic [XLEN-1:0]   mem_req_wdata,
    input  logic              mem_rsp_valid,
    input  logic [XLEN-1:0]   mem_rsp_rdata
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] RSP  = 2'd2;

    logic [1:0]        state_q, state_d;
    logic              owner_q, owner_d;
    logic              wen_q, wen_d;
    logic [XLEN-1:0]   addr_q, addr_d;
    logic [STRB_W-1:0] wstrb_q, wstrb_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic              lsu_pri, grant_lsu, idle, accept, rsp_fire;

`ifdef CORE_MEM_ARB_RR_EN
    logic last_q, last_d;
    // LSU gets priority unless it was the most recent grant (last_q = 1 means LSU)
    always_comb begin
        lsu_pri = !last_q;
        last_d  = accept ? grant_lsu : last_q;
    end
    // last-grant register, reset to IFU
    always_ff @(posedge clk) begin
        last_q <= rst ? 1'b0 : last_d;
    end
`else
    assign lsu_pri = 1'b1;
`endif

    // arbitration, handshakes, response routing and next-state/request-latch logic
    always_comb begin
        idle          = !rst && state_q == IDLE;
        grant_lsu     = lsu_req_valid && (!ifu_req_valid || lsu_pri);
        accept        = idle && (ifu_req_valid || lsu_req_valid);
        ifu_req_ready = idle && ifu_req_valid && !grant_lsu;
        lsu_req_ready = idle && grant_lsu;
        mem_req_valid = !rst && state_q == REQ;
        mem_req_wen   = mem_req_valid && wen_q;
        mem_req_addr  = mem_req_valid ? addr_q : '0;
        mem_req_wstrb = mem_req_valid ? wstrb_q : '0;
        mem_req_wdata = mem_req_valid ? wdata_q : '0;
        rsp_fire      = !rst && mem_rsp_valid && ((state_q == REQ && mem_req_ready) || state_q == RSP);
        ifu_rsp_valid = rsp_fire && !owner_q;
        lsu_rsp_valid = rsp_fire && owner_q;
        ifu_rsp_rdata = ifu_rsp_valid ? mem_rsp_rdata : '0;
        lsu_rsp_rdata = (lsu_rsp_valid && !wen_q) ? mem_rsp_rdata : '0;
        state_d = (state_q == IDLE) ? (accept ? REQ : IDLE) :
                  (state_q == REQ)  ? (mem_req_ready ? (mem_rsp_valid ? IDLE : RSP) : REQ) :
                  (state_q == RSP)  ? (mem_rsp_valid ? IDLE : RSP) : IDLE;
        owner_d = accept ? grant_lsu : owner_q;
        wen_d   = accept ? (grant_lsu && lsu_req_wen) : wen_q;
        addr_d  = accept ? (grant_lsu ? lsu_req_addr : ifu_req_addr) : addr_q;
        wstrb_d = accept ? ((grant_lsu && lsu_req_wen) ? lsu_req_wstrb : '0) : wstrb_q;
        wdata_d = accept ? (grant_lsu ? lsu_req_wdata : '0) : wdata_q;
    end

    // state and latched request registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            wen_q   <= 1'b0;
            addr_q  <= '0;
            wstrb_q <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            wen_q   <= wen_d;
            addr_q  <= addr_d;
            wstrb_q <= wstrb_d;
            wdata_q <= wdata_d;
        end
    end
endmodule

// File: tb/tb_core_mem_arb.sv
// tb_core_mem_arb: table vectors, directed corner sequences and a random run against a transaction model.
module tb_core_mem_arb;
    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid;
    logic [31:0] ifu_req_addr, ifu_rsp_rdata;
    logic        lsu_req_valid, lsu_req_ready, lsu_req_wen, lsu_rsp_valid;
    logic [31:0] lsu_req_addr, lsu_req_wdata, lsu_rsp_rdata;
    logic [3:0]  lsu_req_wstrb;
    logic        mem_req_valid, mem_req_ready, mem_req_wen, mem_rsp_valid;
    logic [31:0] mem_req_addr, mem_req_wdata, mem_rsp_rdata;
    logic [3:0]  mem_req_wstrb;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    core_mem_arb #(.XLEN(32), .STRB_W(4)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
        .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_rdata(ifu_rsp_rdata),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_wen(lsu_req_wen),
        .lsu_req_addr(lsu_req_addr), .lsu_req_wstrb(lsu_req_wstrb), .lsu_req_wdata(lsu_req_wdata),
        .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_rdata(lsu_rsp_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_wen(mem_req_wen),
        .mem_req_addr(mem_req_addr), .mem_req_wstrb(mem_req_wstrb), .mem_req_wdata(mem_req_wdata),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata)
    );

    typedef struct {
        logic        iv;
        logic        lv;
        logic        mr;
        logic        mv;
        logic [31:0] rd;
        logic [4:0]  e;
    } vec_t;

    vec_t tbl[20];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] b(input logic x);
        return {31'd0, x};
    endfunction

    function automatic logic [31:0] ctl();
        return {27'd0, ifu_req_ready, lsu_req_ready, mem_req_valid, ifu_rsp_valid, lsu_rsp_valid};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        ifu_req_valid = 0; ifu_req_addr = 0;
        lsu_req_valid = 0; lsu_req_wen = 0; lsu_req_addr = 0; lsu_req_wstrb = 0; lsu_req_wdata = 0;
        mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_rdata = 0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // transaction-level reference model state for the random phase
    bit          busy, sent, t_owner, t_wen, last_lsu;
    logic [31:0] t_addr, t_wdata;
    logic [3:0]  t_wstrb;

    initial begin
        logic gl, e_ir, e_lr, e_mv, fire, lsu_pri;
        // cycle table: iv lv mr mv rdata expected {ifu_rdy,lsu_rdy,mem_valid,ifu_rsp,lsu_rsp}
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         5'b10000};
        tbl[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0,         5'b00100};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0413, 5'b00010};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         5'b00000};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,         5'b01000};
        tbl[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h1234_5678, 5'b00101};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         5'b10000};
        tbl[7]  = '{1'b0, 1'b0, 1'b1, 1'b1, 32'hCAFE_0001, 5'b00110};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         5'b00000};
        tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         5'b01000};
        tbl[10] = '{1'b1, 1'b0, 1'b1, 1'b1, 32'hA5A5_0001, 5'b00101};
        tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         5'b10000};
        tbl[12] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'hA5A5_0002, 5'b00110};
        tbl[13] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         5'b01000};
        tbl[14] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'hA5A5_0003, 5'b00101};
`ifdef CORE_MEM_ARB_RR_EN
        tbl[15] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         5'b10000};
        tbl[16] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'hA5A5_0004, 5'b00110};
`else
        tbl[15] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         5'b01000};
        tbl[16] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'hA5A5_0004, 5'b00101};
`endif
        tbl[17] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         5'b01000};
        tbl[18] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'hA5A5_0005, 5'b00101};
        tbl[19] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         5'b00000};

        // reset: outputs must be quiet even with every input active
        clr();
        rst = 1;
        tick();
        tick();
        ifu_req_valid = 1; lsu_req_valid = 1; lsu_req_wen = 1; lsu_req_wstrb = 4'hF;
        lsu_req_addr = 32'h1111_2222; lsu_req_wdata = 32'h3333_4444;
        mem_req_ready = 1; mem_rsp_valid = 1; mem_rsp_rdata = 32'h5555_6666;
        #1;
        chk("rst_ctl", ctl(), 32'd0);
        chk("rst_rdata", ifu_rsp_rdata | lsu_rsp_rdata, 32'd0);
        chk("rst_mem", mem_req_addr | mem_req_wdata | {28'd0, mem_req_wstrb} | b(mem_req_wen), 32'd0);
        tick();
        rst = 0;
        clr();

        // table-driven cycles: fetch, same-cycle response, ties
        for (int i = 0; i < 20; i++) begin
            ifu_req_valid = tbl[i].iv; lsu_req_valid = tbl[i].lv;
            mem_req_ready = tbl[i].mr; mem_rsp_valid = tbl[i].mv; mem_rsp_rdata = tbl[i].rd;
            ifu_req_addr = 32'h8000_0000 + 32'(i) * 4; lsu_req_addr = 32'h9000_0000; lsu_req_wen = 0;
            #1;
            chk($sformatf("tbl%0d_ctl", i), ctl(), {27'd0, tbl[i].e});
            if (tbl[i].e[1]) chk($sformatf("tbl%0d_ifu_rdata", i), ifu_rsp_rdata, tbl[i].rd);
            if (tbl[i].e[0]) chk($sformatf("tbl%0d_lsu_rdata", i), lsu_rsp_rdata, tbl[i].rd);
            tick();
        end
        clr();

        // LSU write with memory stalling for three cycles
        lsu_req_valid = 1; lsu_req_wen = 1; lsu_req_addr = 32'h8000_0100;
        lsu_req_wdata = 32'hDEAD_BEEF; lsu_req_wstrb = 4'b0011;
        #1;
        chk("wr_accept", ctl(), 32'b01000);
        tick();
        lsu_req_valid = 0; lsu_req_addr = 32'h0BAD_0BAD; lsu_req_wdata = 0; lsu_req_wstrb = 4'hC; lsu_req_wen = 0;
        for (int i = 0; i < 4; i++) begin
            mem_req_ready = (i == 3);
            #1;
            chk("wr_valid", b(mem_req_valid), 32'd1);
            chk("wr_addr", mem_req_addr, 32'h8000_0100);
            chk("wr_data", mem_req_wdata, 32'hDEAD_BEEF);
            chk("wr_strb_wen", {27'd0, mem_req_wstrb, mem_req_wen}, 32'b00111);
            tick();
        end
        mem_req_ready = 0; mem_rsp_valid = 1; mem_rsp_rdata = 32'hFFFF_FFFF;
        #1;
        chk("wr_ack_ctl", ctl(), 32'b00001);
        chk("wr_ack_rdata", lsu_rsp_rdata, 32'd0);
        tick();
        clr();

        // stray responses in IDLE and in REQ without ready are ignored
        mem_rsp_valid = 1; mem_rsp_rdata = 32'h0000_0077;
        #1;
        chk("stray_idle", ctl(), 32'd0);
        tick();
        mem_rsp_valid = 0; ifu_req_valid = 1; ifu_req_addr = 32'h8000_0040;
        #1;
        chk("f_accept", ctl(), 32'b10000);
        tick();
        ifu_req_valid = 0; mem_rsp_valid = 1; mem_req_ready = 0;
        #1;
        chk("stray_req", ctl(), 32'b00100);
        chk("f_strb_wen", {27'd0, mem_req_wstrb, mem_req_wen}, 32'd0);
        chk("f_addr", mem_req_addr, 32'h8000_0040);
        tick();
        mem_rsp_valid = 0; mem_req_ready = 1;
        #1;
        chk("f_req", ctl(), 32'b00100);
        tick();
        mem_req_ready = 0;
        #1;
        chk("f_wait", ctl(), 32'd0);
        tick();
        mem_rsp_valid = 1;
        #1;
        chk("f_rsp", ctl(), 32'b00010);
        chk("f_rdata", ifu_rsp_rdata, 32'h0000_0077);
        tick();
        clr();

        // reset while in RSP drops the transaction
        ifu_req_valid = 1; ifu_req_addr = 32'h8000_0080;
        tick();
        ifu_req_valid = 0; mem_req_ready = 1;
        tick();
        mem_req_ready = 0; rst = 1; mem_rsp_valid = 1; mem_rsp_rdata = 32'h0000_0099;
        #1;
        chk("rr_rst_ctl", ctl(), 32'd0);
        tick();
        rst = 0;
        #1;
        chk("rr_after_ctl", ctl(), 32'd0);
        chk("rr_after_mem", mem_req_addr | ifu_rsp_rdata | lsu_rsp_rdata, 32'd0);
        tick();
        mem_rsp_valid = 0; ifu_req_valid = 1; ifu_req_addr = 32'h8000_0084;
        #1;
        chk("rr_new_accept", ctl(), 32'b10000);
        tick();
        ifu_req_valid = 0; mem_req_ready = 1; mem_rsp_valid = 1; mem_rsp_rdata = 32'h0000_00AA;
        #1;
        chk("rr_new_rsp", ctl(), 32'b00110);
        chk("rr_new_rdata", ifu_rsp_rdata, 32'h0000_00AA);
        tick();
        clr();

        // random phase: model holds at most one in-flight transaction
        rst = 1;
        tick();
        rst = 0;
        busy = 0; sent = 0; last_lsu = 0;
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 99) == 0);
            ifu_req_valid = 1'($urandom_range(0, 1)); ifu_req_addr = $urandom;
            lsu_req_valid = 1'($urandom_range(0, 1)); lsu_req_wen = 1'($urandom_range(0, 1));
            lsu_req_addr = $urandom; lsu_req_wdata = $urandom; lsu_req_wstrb = 4'($urandom);
            mem_req_ready = 1'($urandom_range(0, 1)); mem_rsp_valid = 1'($urandom_range(0, 1));
            mem_rsp_rdata = $urandom;
            #1;
            if (rst) begin
                chk("rnd_rst", ctl(), 32'd0);
                busy = 0; sent = 0; last_lsu = 0;
            end else begin
`ifdef CORE_MEM_ARB_RR_EN
                lsu_pri = !last_lsu;
`else
                lsu_pri = 1'b1;
`endif
                gl   = lsu_req_valid && (!ifu_req_valid || lsu_pri);
                e_ir = !busy && ifu_req_valid && !gl;
                e_lr = !busy && gl;
                e_mv = busy && !sent;
                fire = busy && mem_rsp_valid && (sent || mem_req_ready);
                chk("rnd_ctl", ctl(), {27'd0, e_ir, e_lr, e_mv, fire && !t_owner, fire && t_owner});
                if (e_mv) begin
                    chk("rnd_addr", mem_req_addr, t_addr);
                    chk("rnd_strb_wen", {27'd0, mem_req_wstrb, mem_req_wen}, {27'd0, t_wstrb, t_wen});
                    if (t_wen) chk("rnd_wdata", mem_req_wdata, t_wdata);
                end
                if (fire && !t_owner) chk("rnd_ifu_rdata", ifu_rsp_rdata, mem_rsp_rdata);
                if (fire && t_owner) chk("rnd_lsu_rdata", lsu_rsp_rdata, t_wen ? 32'd0 : mem_rsp_rdata);
                if (fire) busy = 0;
                else if (busy && !sent && mem_req_ready) sent = 1;
                if (e_ir || e_lr) begin
                    busy = 1; sent = 0; t_owner = gl; last_lsu = gl;
                    t_wen = gl && lsu_req_wen;
                    t_addr = gl ? lsu_req_addr : ifu_req_addr;
                    t_wstrb = t_wen ? lsu_req_wstrb : 4'd0;
                    t_wdata = lsu_req_wdata;
                end
            end
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
